sb_rx_framer: RTL

- Sideband receive framer for the USB4 logical layer; the receive-side counterpart of the sideband transmitter that drives sbtx.
- Deserializes the sbrx bit stream into 10-bit sideband symbols.
- Recognizes Link Transactions (LT) and Administrative Transactions (AT), removes DLE stuffing, checks the AT CRC-16 and presents the decoded transactions to the lane-init/config logic.
- Runs entirely in the sideband clock domain, one bit per sb_clk cycle.

---
 rtl/sb_rx_framer.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/sb_rx_framer.sv
// USB4 sideband receive framer: deserializes sbrx into bytes, decodes LT/AT transactions,
// removes DLE stuffing and checks the AT CRC-16. Optional idle timeout: SB_RX_TIMEOUT_EN.
module sb_rx_framer #(
    parameter int MAX_AT_BYTES = 8,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic                                  sb_clk,
    input  logic                                  rst,
    input  logic                                  sbrx,
    output logic                                  lt_valid,
    output logic [7:0]                            lt_lse,
    output logic                                  at_valid,
    output logic [$clog2(MAX_AT_BYTES+1)-1:0]     at_len,
    output logic [8*MAX_AT_BYTES-1:0]             at_data,
    output logic                                  at_crc_err,
    output logic                                  frame_err,
    output logic                                  busy
);
    localparam int BUF_N = MAX_AT_BYTES + 2;
    localparam int CNT_W = $clog2(BUF_N + 1);
    localparam int IDX_W = $clog2(BUF_N);
    localparam int LEN_W = $clog2(MAX_AT_BYTES + 1);
    localparam logic [7:0] DLE = 8'hFE;
    localparam logic [7:0] STX = 8'h02;
    localparam logic [7:0] ETX = 8'h40;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_STOP} sym_state_t;
    typedef enum logic [2:0] {F_HUNT, F_GOT_DLE, F_LT_CLSE, F_AT_BODY, F_AT_DLE, F_AT_END} frm_state_t;

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h8005;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    sym_state_t       sym_state;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_p0;
    logic [7:0]       sym_byte_p0;
    logic             vld_p0;
    logic             stop_err_p0;

    frm_state_t       frm_state;
    logic [7:0]       lse_q;
    logic [7:0]       buf_q [BUF_N];
    logic [CNT_W-1:0] buf_cnt;
    logic [15:0]      crc_q;

    logic             app_req;
    logic             to_hit;
    logic [IDX_W-1:0] wr_idx, hi_idx, lo_idx;
    logic [8*MAX_AT_BYTES-1:0] payload;
    logic [15:0]      rx_crc;

    // Stage p0: bit sampling and symbol assembly
    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            sym_state   <= S_IDLE;
            bit_cnt     <= 3'd0;
            vld_p0      <= 1'b0;
            stop_err_p0 <= 1'b0;
        end else begin
            vld_p0      <= 1'b0;
            stop_err_p0 <= 1'b0;
            case (sym_state)
                S_IDLE: begin
                    if (!sbrx) begin
                        sym_state <= S_DATA;
                        bit_cnt   <= 3'd0;
                    end
                end
                S_DATA: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) sym_state <= S_STOP;
                end
                S_STOP: begin
                    sym_state <= S_IDLE;
                    if (sbrx) vld_p0      <= 1'b1;
                    else      stop_err_p0 <= 1'b1;
                end
                default: sym_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge sb_clk) begin
        if (sym_state == S_DATA) shift_p0 <= {sbrx, shift_p0[7:1]};
        if (sym_state == S_STOP && sbrx) sym_byte_p0 <= shift_p0;
    end

    always_comb begin
        app_req = vld_p0 && (((frm_state == F_AT_BODY) && (sym_byte_p0 != DLE)) ||
                             ((frm_state == F_AT_DLE)  && (sym_byte_p0 == DLE)));
        wr_idx  = IDX_W'(buf_cnt);
        hi_idx  = IDX_W'(buf_cnt - CNT_W'(2));
        lo_idx  = IDX_W'(buf_cnt - CNT_W'(1));
        rx_crc  = {buf_q[hi_idx], buf_q[lo_idx]};
        payload = '0;
        for (int i = 0; i < MAX_AT_BYTES; i++) begin
            if (i + 2 < int'(buf_cnt)) payload[8*i +: 8] = buf_q[i];
        end
    end

`ifdef SB_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_BITS + 1);
    logic [TO_W-1:0] to_cnt;
    logic            to_idle;

    assign to_idle = ((frm_state == F_AT_BODY) || (frm_state == F_AT_DLE)) &&
                     (sym_state == S_IDLE) && sbrx;
    assign to_hit  = to_idle && (to_cnt == TO_W'(TIMEOUT_BITS - 1));

    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst)                   to_cnt <= '0;
        else if (to_idle && !to_hit) to_cnt <= to_cnt + TO_W'(1);
        else                        to_cnt <= '0;
    end
`else
    assign to_hit = 1'b0;
`endif

    // Stage p1: frame decode, de-stuffing, CRC and transaction outputs
    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            frm_state  <= F_HUNT;
            lse_q      <= 8'h00;
            buf_cnt    <= '0;
            crc_q      <= 16'hFFFF;
            lt_valid   <= 1'b0;
            lt_lse     <= 8'h00;
            at_valid   <= 1'b0;
            at_len     <= '0;
            at_data    <= '0;
            at_crc_err <= 1'b0;
            frame_err  <= 1'b0;
            for (int i = 0; i < BUF_N; i++) buf_q[i] <= 8'h00;
        end else begin
            lt_valid   <= 1'b0;
            at_valid   <= 1'b0;
            at_crc_err <= 1'b0;
            frame_err  <= 1'b0;
            if (stop_err_p0 || to_hit) begin
                frame_err <= 1'b1;
                frm_state <= F_HUNT;
            end else begin
                case (frm_state)
                    F_HUNT: begin
                        if (vld_p0 && sym_byte_p0 == DLE) frm_state <= F_GOT_DLE;
                    end
                    F_GOT_DLE: begin
                        if (vld_p0) begin
                            if (sym_byte_p0 == STX) begin
                                frm_state <= F_AT_BODY;
                                buf_cnt   <= '0;
                                crc_q     <= 16'hFFFF;
                            end else if (sym_byte_p0 != DLE) begin
                                lse_q     <= sym_byte_p0;
                                frm_state <= F_LT_CLSE;
                            end
                        end
                    end
                    F_LT_CLSE: begin
                        if (vld_p0) begin
                            frm_state <= F_HUNT;
                            if (sym_byte_p0 == ~lse_q) begin
                                lt_valid <= 1'b1;
                                lt_lse   <= lse_q;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end
                    end
                    F_AT_BODY: begin
                        if (vld_p0 && sym_byte_p0 == DLE) frm_state <= F_AT_DLE;
                    end
                    F_AT_DLE: begin
                        if (vld_p0) begin
                            if (sym_byte_p0 == DLE) begin
                                frm_state <= F_AT_BODY;
                            end else if (sym_byte_p0 == ETX) begin
                                frm_state <= F_AT_END;
                            end else if (sym_byte_p0 == STX) begin
                                frm_state <= F_AT_BODY;
                                buf_cnt   <= '0;
                                crc_q     <= 16'hFFFF;
                            end else begin
                                frame_err <= 1'b1;
                                frm_state <= F_HUNT;
                            end
                        end
                    end
                    F_AT_END: begin
                        frm_state <= F_HUNT;
                        if (buf_cnt < CNT_W'(3)) begin
                            frame_err <= 1'b1;
                        end else begin
                            at_valid   <= 1'b1;
                            at_len     <= LEN_W'(buf_cnt - CNT_W'(2));
                            at_data    <= payload;
                            at_crc_err <= (crc_q != rx_crc);
                        end
                    end
                    default: frm_state <= F_HUNT;
                endcase
                // CRC lags the buffer by two bytes so the trailing CRC bytes never enter it
                if (app_req) begin
                    if (buf_cnt == CNT_W'(BUF_N)) begin
                        frame_err <= 1'b1;
                        frm_state <= F_HUNT;
                    end else begin
                        buf_q[wr_idx] <= sym_byte_p0;
                        buf_cnt       <= buf_cnt + CNT_W'(1);
                        if (buf_cnt >= CNT_W'(2)) crc_q <= crc16_byte(crc_q, buf_q[hi_idx]);
                    end
                end
            end
        end
    end

    assign busy = (sym_state != S_IDLE) || (frm_state != F_HUNT);

endmodule
